iob_axi_bridge: RTL

Single-beat bridge from the native IOb request bus (CPU data port) to an AXI4 master port. It sits directly upstream of the AXI4 RAM/interconnect and turns each IOb request into one AXI4 transaction (len 0, INCR, full-width size). It drives the AW, W and B channels for writes and the AR and R channels for reads, then returns completion and read data to the IOb side.

---
 rtl/iob_axi_bridge_pkg.sv | 16 +
 rtl/iob_axi_bridge_wr_ch.sv | 64 ++++++
 rtl/iob_axi_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_axi_bridge_pkg.sv
// Shared types and AXI constants for the IOb-to-AXI4 single-beat bridge.
package iob_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ_ADDR,
        READ_DATA
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/iob_axi_bridge_wr_ch.sv
// AW/W channel driver: registers the write beat and tracks the two handshakes
// independently so they may complete in either order or together.
module iob_axi_bridge_wr_ch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [STRB_WIDTH-1:0] strb,
    input  logic                  awready,
    input  logic                  wready,
    output logic                  awvalid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  wvalid,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  done
);

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Includes handshakes completing this cycle so the FSM can advance on the same edge.
    assign done = (aw_done | aw_hs) & (w_done | w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= addr;
            wdata   <= data;
            wstrb   <= strb;
        end else begin
            if (aw_hs) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_axi_bridge.sv
// IOb request bus to AXI4 master, one single-beat transaction per request.
// Optional posted writes with B credit counting: IOB_AXI_BRIDGE_POSTED_WR_EN.
module iob_axi_bridge
    import iob_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int LEN_WIDTH       = 8,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  iob_valid_i,
    input  logic [ADDR_WIDTH-1:0] iob_addr_i,
    input  logic [DATA_WIDTH-1:0] iob_wdata_i,
    input  logic [STRB_WIDTH-1:0] iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_WIDTH-1:0] iob_rdata_o,
    output logic                  err_o,
    output logic [ID_WIDTH-1:0]   axi_awid_o,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic [LEN_WIDTH-1:0]  axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic [1:0]            axi_awlock_o,
    output logic [3:0]            axi_awcache_o,
    output logic [2:0]            axi_awprot_o,
    output logic [3:0]            axi_awqos_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [STRB_WIDTH-1:0] axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [ID_WIDTH-1:0]   axi_bid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    output logic [ID_WIDTH-1:0]   axi_arid_o,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [LEN_WIDTH-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [1:0]            axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [2:0]            axi_arprot_o,
    output logic [3:0]            axi_arqos_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [ID_WIDTH-1:0]   axi_rid_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

    state_t                state_q, state_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  err_q, err_d;
    logic                  wr_start;
    logic                  wr_done;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  b_hs;
    logic                  r_hs;

    assign axi_awid_o    = ID_WIDTH'(AXI_ID);
    assign axi_awlen_o   = '0;
    assign axi_awsize_o  = AXI_SIZE;
    assign axi_awburst_o = BURST_INCR;
    assign axi_awlock_o  = '0;
    assign axi_awcache_o = CACHE_DEFAULT;
    assign axi_awprot_o  = '0;
    assign axi_awqos_o   = '0;
    assign axi_wlast_o   = 1'b1;
    assign axi_arid_o    = ID_WIDTH'(AXI_ID);
    assign axi_araddr_o  = araddr_q;
    assign axi_arlen_o   = '0;
    assign axi_arsize_o  = AXI_SIZE;
    assign axi_arburst_o = BURST_INCR;
    assign axi_arlock_o  = '0;
    assign axi_arcache_o = CACHE_DEFAULT;
    assign axi_arprot_o  = '0;
    assign axi_arqos_o   = '0;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;
    assign iob_ready_o   = ready_q;
    assign iob_rvalid_o  = rvalid_q;
    assign iob_rdata_o   = rdata_q;
    assign err_o         = err_q;
    assign r_hs          = axi_rvalid_i & rready_q;

    iob_axi_bridge_wr_ch #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_wr_ch (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .start  (wr_start),
        .addr   (iob_addr_i),
        .data   (iob_wdata_i),
        .strb   (iob_wstrb_i),
        .awready(axi_awready_i),
        .wready (axi_wready_i),
        .awvalid(axi_awvalid_o),
        .awaddr (axi_awaddr_o),
        .wvalid (axi_wvalid_o),
        .wdata  (axi_wdata_o),
        .wstrb  (axi_wstrb_o),
        .done   (wr_done)
    );

`ifdef IOB_AXI_BRIDGE_POSTED_WR_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [CNT_W-1:0] out_cnt;
    logic             cnt_inc;
    logic             cnt_dec;

    assign cnt_inc      = (state_q == WRITE) && wr_done;
    assign cnt_dec      = axi_bvalid_i && (out_cnt != '0);
    assign wr_ok        = (out_cnt != CNT_W'(MAX_OUTSTANDING));
    // Reads wait for every posted write to be acknowledged to keep read-after-write order.
    assign rd_ok        = (out_cnt == '0);
    assign b_hs         = axi_bvalid_i;
    assign axi_bready_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end
`else
    logic bready_q, bready_d;
    logic unused_cfg;

    assign wr_ok        = 1'b1;
    assign rd_ok        = 1'b1;
    assign b_hs         = axi_bvalid_i & bready_q;
    assign axi_bready_o = bready_q;
    assign unused_cfg   = (MAX_OUTSTANDING > 1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bready_q <= 1'b0;
        end else begin
            bready_q <= bready_d;
        end
    end
`endif

    logic unused_inputs;
    assign unused_inputs = ^{axi_bid_i, axi_rid_i, axi_rlast_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            araddr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            araddr_q  <= araddr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ready_d   = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        araddr_d  = araddr_q;
        err_d     = err_q;
        wr_start  = 1'b0;
`ifndef IOB_AXI_BRIDGE_POSTED_WR_EN
        bready_d  = bready_q;
`endif
        case (state_q)
            IDLE: begin
                // The request is still held during the completion pulse; skip that cycle.
                if (iob_valid_i && !ready_q) begin
                    if (|iob_wstrb_i) begin
                        if (wr_ok) begin
                            wr_start = 1'b1;
                            state_d  = WRITE;
                        end
                    end else if (rd_ok) begin
                        arvalid_d = 1'b1;
                        araddr_d  = iob_addr_i;
                        state_d   = READ_ADDR;
                    end
                end
            end
            WRITE: begin
                if (wr_done) begin
`ifdef IOB_AXI_BRIDGE_POSTED_WR_EN
                    ready_d  = 1'b1;
                    state_d  = IDLE;
`else
                    bready_d = 1'b1;
                    state_d  = WRESP;
`endif
                end
            end
`ifndef IOB_AXI_BRIDGE_POSTED_WR_EN
            WRESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            READ_ADDR: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = READ_DATA;
                end
            end
            READ_DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    rdata_d  = axi_rdata_i;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (b_hs && (axi_bresp_i != RESP_OKAY)) err_d = 1'b1;
        if (r_hs && (axi_rresp_i != RESP_OKAY)) err_d = 1'b1;
    end

endmodule
